mem_arbiter: RTL

Arbitrates the single unified memory port of the ARM 32-bit core between the instruction-fetch stage and the memory-access stage of `dataPath`. Each requester holds a level request. The block grants the port using round-robin on ties and registers the winner's command onto the memory bus. It returns a one-cycle `ready` pulse to the winner, and that pulse also serves as the stall-release signal. A watchdog aborts transactions that the memory never acknowledges.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch and data requester ports, the unified memory port
// and the sticky error flag. The arbiter uses the slave view, its environment the master view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with a registered command, one-cycle ready pulses and a watchdog abort.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned     CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;
  typedef enum logic {OwnI, OwnD} owner_e;

  state_e            state_q, state_d;
  owner_e            last_q, last_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              grant_i, grant_d;
  logic              if_ready_c, d_ready_c;
  logic [DATA_W-1:0] if_rdata_c, d_rdata_c;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    if_ready_c = 1'b0;
    d_ready_c  = 1'b0;
    if_rdata_c = '0;
    d_rdata_c  = '0;

    unique case (state_q)
      StIdle: begin
        // On a tie the requester that did not win last time goes first.
        if (bus.if_req && (!bus.d_req || last_q == OwnD)) begin
          grant_i = 1'b1;
        end else if (bus.d_req) begin
          grant_d = 1'b1;
        end
      end
      StBusyI: begin
        if (bus.mem_ack) begin
          if_ready_c = 1'b1;
          if_rdata_c = bus.mem_rdata;
          if (bus.d_req) grant_d = 1'b1;
          else           state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          if_ready_c = 1'b1;
          err_d      = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBusyD: begin
        if (bus.mem_ack) begin
          d_ready_c = 1'b1;
          d_rdata_c = bus.mem_rdata;
          if (bus.if_req) grant_i = 1'b1;
          else            state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          d_ready_c = 1'b1;
          err_d     = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (grant_i) begin
      state_d = StBusyI;
      last_d  = OwnI;
      cnt_d   = '0;
      addr_d  = bus.if_addr;
      we_d    = 1'b0;
      wdata_d = '0;
    end
    if (grant_d) begin
      state_d = StBusyD;
      last_d  = OwnD;
      cnt_d   = '0;
      addr_d  = bus.d_addr;
      we_d    = bus.d_we;
      wdata_d = bus.d_wdata;
    end

    // A transaction caught by reset is dropped without a completion pulse.
    if (rst) begin
      if_ready_c = 1'b0;
      d_ready_c  = 1'b0;
      if_rdata_c = '0;
      d_rdata_c  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= OwnD;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_req   = (state_q == StBusyI) || (state_q == StBusyD);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ready  = if_ready_c;
  assign bus.if_rdata  = if_rdata_c;
  assign bus.d_ready   = d_ready_c;
  assign bus.d_rdata   = d_rdata_c;
  assign bus.err       = err_q;

endmodule
